// File: rtl/jpeg_marker_ctrl.sv
// JPEG container parser: routes header segments to table loaders and scan bytes to jpeg_stream.
// Optional macro JPEG_RSTM_STRIP_EN strips RSTn markers from the scan and pulses rst_mark.
module jpeg_marker_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] hdr_data,
    output logic       hdr_we,
    output logic [7:0] hdr_code,
    output logic       seg_start,
    output logic       seg_end,
    output logic [7:0] strm_din,
    output logic       strm_we,
    input  logic       strm_next,
    output logic       frame_done,
`ifdef JPEG_RSTM_STRIP_EN
    output logic       rst_mark,
`endif
    output logic       err
);
    // state    | meaning
    // SEEK_SOI | discard until FF,D8
    // MARKER   | expect FF introducing a marker
    // CODE     | marker code byte (FF fill allowed)
    // LEN_HI   | segment length, high byte
    // LEN_LO   | segment length, low byte
    // PAYLOAD  | header bytes to hdr_data
    // SCAN     | entropy-coded bytes to jpeg_stream
    // ERROR    | malformed stream, wait for reset
    typedef enum logic [2:0] {
        SEEK_SOI, MARKER, CODE, LEN_HI, LEN_LO, PAYLOAD, SCAN, ERROR
    } state_t;

    state_t      state;
    logic        prev_ff;
    logic [7:0]  len_hi;
    logic [15:0] cnt;
    logic        first;
    logic [15:0] seg_len;
    logic        accept;
`ifdef JPEG_RSTM_STRIP_EN
    logic        pend;
    logic        is_rst;
    assign is_rst = (in_data[7:3] == 5'b11010);
`endif

    assign accept  = in_valid & in_ready;
    assign seg_len = {len_hi, in_data};

    always_comb begin
        strm_din = in_data;
        strm_we  = 1'b0;
        in_ready = 1'b1;
        if (state == SCAN) begin
`ifdef JPEG_RSTM_STRIP_EN
            // A held FF drains ahead of the current byte unless that byte makes it a restart marker.
            if (pend) begin
                if (!is_rst) begin
                    strm_din = 8'hFF;
                    strm_we  = in_valid;
                    in_ready = 1'b0;
                end
            end else if (in_data != 8'hFF) begin
                strm_we  = in_valid;
                in_ready = strm_next;
            end
`else
            strm_we  = in_valid;
            in_ready = strm_next;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEEK_SOI;
            prev_ff    <= 1'b0;
            len_hi     <= 8'h00;
            cnt        <= 16'h0000;
            first      <= 1'b0;
            hdr_data   <= 8'h00;
            hdr_we     <= 1'b0;
            hdr_code   <= 8'h00;
            seg_start  <= 1'b0;
            seg_end    <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
`ifdef JPEG_RSTM_STRIP_EN
            pend       <= 1'b0;
            rst_mark   <= 1'b0;
`endif
        end else begin
            hdr_we     <= 1'b0;
            seg_start  <= 1'b0;
            seg_end    <= 1'b0;
            frame_done <= 1'b0;
`ifdef JPEG_RSTM_STRIP_EN
            rst_mark   <= 1'b0;
`endif
            case (state)
                SEEK_SOI: if (accept) begin
                    if (prev_ff && in_data == 8'hD8) state <= MARKER;
                    prev_ff <= (in_data == 8'hFF);
                end
                MARKER: if (accept) begin
                    if (in_data == 8'hFF) begin
                        state <= CODE;
                    end else begin
                        state <= ERROR;
                        err   <= 1'b1;
                    end
                end
                CODE: if (accept) begin
                    case (in_data)
                        8'hFF: state <= CODE;
                        8'hD9: begin
                            frame_done <= 1'b1;
                            prev_ff    <= 1'b0;
                            state      <= SEEK_SOI;
                        end
                        8'h01, 8'hD0, 8'hD1, 8'hD2, 8'hD3,
                        8'hD4, 8'hD5, 8'hD6, 8'hD7: state <= MARKER;
                        8'hD8, 8'h00: begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                        default: begin
                            hdr_code <= in_data;
                            state    <= LEN_HI;
                        end
                    endcase
                end
                LEN_HI: if (accept) begin
                    len_hi <= in_data;
                    state  <= LEN_LO;
                end
                LEN_LO: if (accept) begin
                    if (seg_len < 16'd2) begin
                        state <= ERROR;
                        err   <= 1'b1;
                    end else if (seg_len == 16'd2) begin
                        seg_start <= 1'b1;
                        seg_end   <= 1'b1;
                        prev_ff   <= 1'b0;
                        state     <= (hdr_code == 8'hDA) ? SCAN : MARKER;
                    end else begin
                        cnt   <= seg_len - 16'd2;
                        first <= 1'b1;
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: if (accept) begin
                    hdr_data  <= in_data;
                    hdr_we    <= 1'b1;
                    seg_start <= first;
                    first     <= 1'b0;
                    cnt       <= cnt - 16'd1;
                    if (cnt == 16'd1) begin
                        seg_end <= 1'b1;
                        prev_ff <= 1'b0;
                        state   <= (hdr_code == 8'hDA) ? SCAN : MARKER;
                    end
                end
                SCAN: begin
`ifdef JPEG_RSTM_STRIP_EN
                    if (pend) begin
                        if (in_valid && is_rst) begin
                            pend     <= 1'b0;
                            prev_ff  <= 1'b0;
                            rst_mark <= 1'b1;
                        end else if (in_valid && strm_next) begin
                            pend    <= 1'b0;
                            prev_ff <= 1'b1;
                        end
                    end else if (accept) begin
                        if (in_data == 8'hFF) begin
                            pend <= 1'b1;
                        end else if (prev_ff && in_data == 8'hD9) begin
                            frame_done <= 1'b1;
                            prev_ff    <= 1'b0;
                            state      <= SEEK_SOI;
                        end else begin
                            prev_ff <= 1'b0;
                        end
                    end
`else
                    if (accept) begin
                        if (prev_ff && in_data == 8'hD9) begin
                            frame_done <= 1'b1;
                            prev_ff    <= 1'b0;
                            state      <= SEEK_SOI;
                        end else begin
                            prev_ff <= (in_data == 8'hFF);
                        end
                    end
`endif
                end
                ERROR: err <= 1'b1;
            endcase
        end
    end
endmodule
